// File: rtl/execute_if.sv
// Handshake bundle for the execute stage: operation input, memory request/response port,
// registered result output and per-type operation counters.
interface execute_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_type;
   logic [2:0]       in_func;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [XLEN-1:0]  in_imm;
   logic [XLEN-1:0]  in_pc;
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic [XLEN-1:0]  mem_req_addr;
   logic             mem_req_we;
   logic [XLEN-1:0]  mem_req_wdata;
   logic             mem_rsp_valid;
   logic [XLEN-1:0]  mem_rsp_rdata;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic             out_taken;
   logic [XLEN-1:0]  out_target;
   logic             out_illegal;
   logic [CNT_W-1:0] cnt_alu;
   logic [CNT_W-1:0] cnt_mem;
   logic [CNT_W-1:0] cnt_branch;
   logic [CNT_W-1:0] cnt_illegal;

   modport master (
      output in_valid, in_type, in_func, in_a, in_b, in_imm, in_pc,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
      input  in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
      input  out_valid, out_result, out_taken, out_target, out_illegal,
      input  cnt_alu, cnt_mem, cnt_branch, cnt_illegal
   );

   modport slave (
      input  in_valid, in_type, in_func, in_a, in_b, in_imm, in_pc,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
      output in_ready, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
      output out_valid, out_result, out_taken, out_target, out_illegal,
      output cnt_alu, cnt_mem, cnt_branch, cnt_illegal
   );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: ALU/branch/illegal complete in 1 cycle, store in >=2, load in >=3 via the memory port.
// Result register holds until out_ready; no accept while a result is stuck or a memory op is in flight.
module execute_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input logic      clk,
   input logic      rst_n,
   execute_if.slave bus
);
   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE = 2'd0, MEM_REQ = 2'd1, MEM_WAIT = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic             out_taken_q, out_taken_d;
   logic             out_illegal_q, out_illegal_d;
   logic [XLEN-1:0]  out_result_q, out_result_d;
   logic [XLEN-1:0]  out_target_q, out_target_d;
   logic [XLEN-1:0]  req_addr_q, req_addr_d;
   logic [XLEN-1:0]  req_wdata_q, req_wdata_d;
   logic             req_we_q, req_we_d;
   logic [CNT_W-1:0] cnt_alu_q, cnt_mem_q, cnt_branch_q, cnt_illegal_q;
   logic             accept;
   logic             op_illegal;
   logic             br_taken;
   logic [XLEN-1:0]  alu_res;

   assign bus.in_ready      = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept            = bus.in_valid && bus.in_ready;
   // Branch encodings 110/111 are reserved and fold into the illegal class.
   assign op_illegal        = (bus.in_type == 2'b11) ||
                              ((bus.in_type == 2'b10) && (bus.in_func[2:1] == 2'b11));

   assign bus.mem_req_valid = (state_q == MEM_REQ);
   assign bus.mem_req_addr  = req_addr_q;
   assign bus.mem_req_we    = req_we_q;
   assign bus.mem_req_wdata = req_wdata_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_result    = out_result_q;
   assign bus.out_taken     = out_taken_q;
   assign bus.out_target    = out_target_q;
   assign bus.out_illegal   = out_illegal_q;
   assign bus.cnt_alu       = cnt_alu_q;
   assign bus.cnt_mem       = cnt_mem_q;
   assign bus.cnt_branch    = cnt_branch_q;
   assign bus.cnt_illegal   = cnt_illegal_q;

   always_comb begin
      alu_res = '0;
      case (bus.in_func)
         3'b000:  alu_res = bus.in_a + bus.in_b;
         3'b001:  alu_res = bus.in_a - bus.in_b;
         3'b010:  alu_res = bus.in_a & bus.in_b;
         3'b011:  alu_res = bus.in_a | bus.in_b;
         3'b100:  alu_res = bus.in_a ^ bus.in_b;
         3'b101:  alu_res = bus.in_a << bus.in_b[SH_W-1:0];
         3'b110:  alu_res = bus.in_a >> bus.in_b[SH_W-1:0];
         default: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (bus.in_func)
         3'b000:  br_taken = (bus.in_a == bus.in_b);
         3'b001:  br_taken = (bus.in_a != bus.in_b);
         3'b010:  br_taken = ($signed(bus.in_a) <  $signed(bus.in_b));
         3'b011:  br_taken = ($signed(bus.in_a) >= $signed(bus.in_b));
         3'b100:  br_taken = (bus.in_a <  bus.in_b);
         3'b101:  br_taken = (bus.in_a >= bus.in_b);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q && !bus.out_ready;
      out_result_d  = out_result_q;
      out_taken_d   = out_taken_q;
      out_target_d  = out_target_q;
      out_illegal_d = out_illegal_q;
      req_addr_d    = req_addr_q;
      req_we_d      = req_we_q;
      req_wdata_d   = req_wdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.in_type == 2'b01) begin
                  req_addr_d  = bus.in_a + bus.in_imm;
                  req_we_d    = bus.in_func[0];
                  req_wdata_d = bus.in_b;
                  state_d     = MEM_REQ;
               end else begin
                  out_valid_d   = 1'b1;
                  out_result_d  = '0;
                  out_taken_d   = 1'b0;
                  out_target_d  = '0;
                  out_illegal_d = 1'b0;
                  if (op_illegal) begin
                     out_illegal_d = 1'b1;
                  end else if (bus.in_type == 2'b00) begin
                     out_result_d = alu_res;
                  end else begin
                     out_result_d = bus.in_pc + XLEN'(4);
                     out_target_d = bus.in_pc + bus.in_imm;
                     out_taken_d  = br_taken;
                  end
               end
            end
         end
         MEM_REQ: begin
            if (bus.mem_req_ready) begin
               if (req_we_q) begin
                  out_valid_d   = 1'b1;
                  out_result_d  = '0;
                  out_taken_d   = 1'b0;
                  out_target_d  = '0;
                  out_illegal_d = 1'b0;
                  state_d       = IDLE;
               end else begin
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (bus.mem_rsp_valid) begin
               out_valid_d   = 1'b1;
               out_result_d  = bus.mem_rsp_rdata;
               out_taken_d   = 1'b0;
               out_target_d  = '0;
               out_illegal_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_taken_q   <= 1'b0;
         out_target_q  <= '0;
         out_illegal_q <= 1'b0;
         req_addr_q    <= '0;
         req_we_q      <= 1'b0;
         req_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_taken_q   <= out_taken_d;
         out_target_q  <= out_target_d;
         out_illegal_q <= out_illegal_d;
         req_addr_q    <= req_addr_d;
         req_we_q      <= req_we_d;
         req_wdata_q   <= req_wdata_d;
      end
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_alu_q     <= '0;
         cnt_mem_q     <= '0;
         cnt_branch_q  <= '0;
         cnt_illegal_q <= '0;
      end else if (accept) begin
         if (op_illegal) begin
            cnt_illegal_q <= sat_inc(cnt_illegal_q);
         end else begin
            case (bus.in_type)
               2'b00:   cnt_alu_q    <= sat_inc(cnt_alu_q);
               2'b01:   cnt_mem_q    <= sat_inc(cnt_mem_q);
               default: cnt_branch_q <= sat_inc(cnt_branch_q);
            endcase
         end
      end
   end
endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed scenarios plus randomized traffic
// scored against an arithmetic reference model and a result queue.
module tb_execute_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   execute_if #(.XLEN(32), .CNT_W(16)) bus ();
   execute_if #(.XLEN(32), .CNT_W(2))  sbus ();

   execute_unit #(.XLEN(32), .CNT_W(16)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
   execute_unit #(.XLEN(32), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

   typedef struct packed {
      logic        ill;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] res;
   } exp_t;

   int total = 0;
   int bad   = 0;
   int e_alu = 0, e_mem = 0, e_br = 0, e_ill = 0;

   function automatic exp_t ref_exec(input logic [1:0] t, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm, input logic [31:0] pc);
      exp_t   e;
      longint ua, ub, upc, uimm, p2;
      int     sa, sb, sh;
      e    = '0;
      ua   = longint'({32'h0, a});
      ub   = longint'({32'h0, b});
      upc  = longint'({32'h0, pc});
      uimm = longint'({32'h0, imm});
      sa   = $signed(a);
      sb   = $signed(b);
      sh   = int'(b % 32);
      p2   = 1;
      for (int k = 0; k < sh; k++) p2 = p2 * 2;
      if (t == 2'd0) begin
         case (f)
            3'd0: e.res = 32'(ua + ub);
            3'd1: e.res = 32'(ua - ub);
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = 32'(ua * p2);
            3'd6: e.res = 32'(ua / p2);
            default: e.res = (sa < sb) ? 32'd1 : 32'd0;
         endcase
      end else if (t == 2'd2 && f <= 3'd5) begin
         e.res = 32'(upc + 4);
         e.tgt = 32'(upc + uimm);
         case (f)
            3'd0: e.tk = (ua == ub);
            3'd1: e.tk = (ua != ub);
            3'd2: e.tk = (sa < sb);
            3'd3: e.tk = (sa >= sb);
            3'd4: e.tk = (ua < ub);
            default: e.tk = (ua >= ub);
         endcase
      end else if (t != 2'd1) begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic note_accept(input logic [1:0] t, input logic [2:0] f);
      if (t == 2'd3 || (t == 2'd2 && f > 3'd5)) e_ill++;
      else if (t == 2'd0) e_alu++;
      else if (t == 2'd1) e_mem++;
      else e_br++;
   endtask

   task automatic set_op(input logic [1:0] t, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_type  = t;
      bus.in_func  = f;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_imm   = imm;
      bus.in_pc    = pc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++;
      if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%b want=0", bus.mem_req_valid); end
      total++;
      if ({bus.out_taken, bus.out_illegal, bus.out_result, bus.out_target} !== 66'h0) begin
         bad++; $display("FAIL reset_out_fields got=%b %b %h %h want=0", bus.out_taken, bus.out_illegal, bus.out_result, bus.out_target);
      end
      total++;
      if ({bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata} !== 65'h0) begin
         bad++; $display("FAIL reset_mem_req got=%h %b %h want=0", bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata);
      end
      total++;
      if ({bus.cnt_alu, bus.cnt_mem, bus.cnt_branch, bus.cnt_illegal} !== 64'h0) begin
         bad++; $display("FAIL reset_counters got=%h %h %h %h want=0", bus.cnt_alu, bus.cnt_mem, bus.cnt_branch, bus.cnt_illegal);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      total++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu_add();
      bus.out_ready = 1'b1;
      set_op(2'd0, 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
      #1;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b want=1", bus.in_ready); end
      total++;
      note_accept(2'd0, 3'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL add_result got=%b/%h want=1/00000000", bus.out_valid, bus.out_result);
      end
      total++;
      if (bus.cnt_alu !== 16'd1) begin bad++; $display("FAIL add_cnt_alu got=%0d want=1", bus.cnt_alu); end
      total++;
      @(negedge clk);
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_retire got=%b want=0", bus.out_valid); end
      total++;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  fs [4];
      logic [31:0] as [4];
      logic [31:0] bs [4];
      logic [31:0] xs [4];
      logic [2:0]  f;
      logic [31:0] a, b;
      exp_t        e;
      fs = '{3'd1, 3'd7, 3'd6, 3'd5};
      as = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
      bs = '{32'd7, 32'd1, 32'd31, 32'd35};
      xs = '{32'hFFFF_FFFE, 32'd1, 32'd1, 32'd8};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_op(2'd0, fs[i], as[i], bs[i], 32'h0, 32'h0);
         #1;
         if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready op=%0d got=%b want=1", i, bus.in_ready); end
         total++;
         note_accept(2'd0, fs[i]);
         @(negedge clk);
         if ({bus.out_valid, bus.out_result} !== {1'b1, xs[i]}) begin
            bad++; $display("FAIL b2b_result op=%0d got=%b/%h want=1/%h", i, bus.out_valid, bus.out_result, xs[i]);
         end
         total++;
      end
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         e = ref_exec(2'd0, f, a, b, 32'h0, 32'h0);
         set_op(2'd0, f, a, b, $urandom, $urandom);
         note_accept(2'd0, f);
         @(negedge clk);
         if ({bus.out_valid, bus.out_result, bus.out_taken, bus.out_target, bus.out_illegal} !==
             {1'b1, e.res, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL alu_rand f=%0d a=%h b=%h got=%b/%h/%b/%h/%b want=1/%h/0/0/0", f, a, b,
                            bus.out_valid, bus.out_result, bus.out_taken, bus.out_target, bus.out_illegal, e.res);
         end
         total++;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.cnt_alu !== 16'(e_alu)) begin bad++; $display("FAIL b2b_cnt_alu got=%0d want=%0d", bus.cnt_alu, e_alu); end
      total++;
   endtask

   task automatic test_branch();
      logic [2:0]  f;
      logic [31:0] a, b, imm, pc;
      exp_t        e;
      bus.out_ready = 1'b1;
      set_op(2'd2, 3'd4, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h100);
      note_accept(2'd2, 3'd4);
      @(negedge clk);
      set_op(2'd2, 3'd7, 32'h5, 32'h5, 32'h10, 32'h200);
      if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_result, bus.out_illegal} !==
          {1'b1, 1'b1, 32'hF0, 32'h104, 1'b0}) begin
         bad++; $display("FAIL bltu got=%b/%b/%h/%h/%b want=1/1/000000f0/00000104/0",
                         bus.out_valid, bus.out_taken, bus.out_target, bus.out_result, bus.out_illegal);
      end
      total++;
      note_accept(2'd2, 3'd7);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if ({bus.out_valid, bus.out_illegal, bus.out_taken} !== 3'b110) begin
         bad++; $display("FAIL br_func7 got=%b/%b/%b want=1/1/0", bus.out_valid, bus.out_illegal, bus.out_taken);
      end
      total++;
      if ({bus.cnt_illegal, bus.cnt_branch} !== {16'd1, 16'd1}) begin
         bad++; $display("FAIL br_counts got=ill %0d br %0d want=ill 1 br 1", bus.cnt_illegal, bus.cnt_branch);
      end
      total++;
      for (int i = 0; i < 24; i++) begin
         f   = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         imm = $urandom;
         pc  = $urandom;
         e   = ref_exec(2'd2, f, a, b, imm, pc);
         set_op(2'd2, f, a, b, imm, pc);
         note_accept(2'd2, f);
         @(negedge clk);
         if ({bus.out_valid, bus.out_illegal, bus.out_taken} !== {1'b1, e.ill, e.tk} ||
             (!e.ill && {bus.out_result, bus.out_target} !== {e.res, e.tgt})) begin
            bad++; $display("FAIL br_rand f=%0d a=%h b=%h got=%b/%b/%b/%h/%h want=1/%b/%b/%h/%h", f, a, b,
                            bus.out_valid, bus.out_illegal, bus.out_taken, bus.out_result, bus.out_target,
                            e.ill, e.tk, e.res, e.tgt);
         end
         total++;
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      if ({bus.cnt_branch, bus.cnt_illegal} !== {16'(e_br), 16'(e_ill)}) begin
         bad++; $display("FAIL br_rand_counts got=%0d/%0d want=%0d/%0d", bus.cnt_branch, bus.cnt_illegal, e_br, e_ill);
      end
      total++;
   endtask

   task automatic test_mem();
      bus.out_ready     = 1'b1;
      bus.mem_req_ready = 1'b0;
      set_op(2'd1, 3'd0, 32'h1000, 32'h0, 32'h4, 32'h0);
      note_accept(2'd1, 3'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.in_ready} !== {1'b1, 32'h1004, 1'b0, 1'b0}) begin
            bad++; $display("FAIL load_req_pending cyc=%0d got=%b/%h/%b/%b want=1/00001004/0/0", k,
                            bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.in_ready);
         end
         total++;
         @(negedge clk);
      end
      // response coinciding with the request handshake must be dropped
      bus.mem_req_ready = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h1234_5678;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if ({bus.mem_req_valid, bus.out_valid, bus.in_ready} !== 3'b000) begin
         bad++; $display("FAIL load_wait got=%b/%b/%b want=0/0/0", bus.mem_req_valid, bus.out_valid, bus.in_ready);
      end
      total++;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if ({bus.out_valid, bus.out_result, bus.out_taken, bus.out_illegal} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
         bad++; $display("FAIL load_result got=%b/%h/%b/%b want=1/deadbeef/0/0",
                         bus.out_valid, bus.out_result, bus.out_taken, bus.out_illegal);
      end
      total++;
      set_op(2'd1, 3'd1, 32'h2000, 32'hCAFE_F00D, 32'h8, 32'h0);
      note_accept(2'd1, 3'd1);
      @(negedge clk);
      bus.in_valid      = 1'b0;
      bus.mem_req_ready = 1'b1;
      #1;
      if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata} !==
          {1'b1, 1'b1, 32'h2008, 32'hCAFE_F00D}) begin
         bad++; $display("FAIL store_req got=%b/%b/%h/%h want=1/1/00002008/cafef00d",
                         bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata);
      end
      total++;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'h0}) begin
         bad++; $display("FAIL store_result got=%b/%h want=1/00000000", bus.out_valid, bus.out_result);
      end
      total++;
      if (bus.cnt_mem !== 16'(e_mem)) begin bad++; $display("FAIL mem_count got=%0d want=%0d", bus.cnt_mem, e_mem); end
      total++;
      @(negedge clk);
   endtask

   task automatic test_stall();
      bus.out_ready = 1'b0;
      set_op(2'd0, 3'd0, 32'd3, 32'd4, 32'h0, 32'h0);
      note_accept(2'd0, 3'd0);
      @(negedge clk);
      set_op(2'd0, 3'd4, 32'hF0, 32'hFF, 32'h0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         #1;
         if ({bus.out_valid, bus.out_result, bus.in_ready} !== {1'b1, 32'd7, 1'b0}) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b want=1/00000007/0", k,
                            bus.out_valid, bus.out_result, bus.in_ready);
         end
         total++;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", bus.in_ready); end
      total++;
      note_accept(2'd0, 3'd4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if ({bus.out_valid, bus.out_result} !== {1'b1, 32'h0F}) begin
         bad++; $display("FAIL stall_next got=%b/%h want=1/0000000f", bus.out_valid, bus.out_result);
      end
      total++;
      if (bus.cnt_alu !== 16'(e_alu)) begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", bus.cnt_alu, e_alu); end
      total++;
      @(negedge clk);
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_retire got=%b want=0", bus.out_valid); end
      total++;
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        e, h;
      logic        ld_wait, acc_last, offer;
      logic [31:0] x_addr, x_wdata;
      logic        x_we;
      logic [1:0]  t;
      logic [2:0]  f;
      ld_wait  = 1'b0;
      acc_last = 1'b1;
      x_addr   = '0;
      x_wdata  = '0;
      x_we     = 1'b0;
      for (int cyc = 0; cyc < 460; cyc++) begin
         offer = (cyc < 420);
         if (!offer) begin
            bus.in_valid = 1'b0;
         end else if (!bus.in_valid || acc_last) begin
            if ($urandom_range(0, 4) != 0) begin
               set_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, $urandom, $urandom);
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready     = !offer || ($urandom_range(0, 3) != 0);
         bus.mem_req_ready = !offer || ($urandom_range(0, 1) != 0);
         bus.mem_rsp_valid = ld_wait ? (!offer || $urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bus.mem_rsp_rdata = $urandom;
         #1;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               bad++; $display("FAIL rand_spurious_out cyc=%0d got=%h want=no result", cyc, bus.out_result);
            end else begin
               h = q.pop_front();
               if ({bus.out_illegal, bus.out_taken, bus.out_target, bus.out_result} !== h) begin
                  bad++; $display("FAIL rand_out cyc=%0d got=%b/%b/%h/%h want=%b/%b/%h/%h", cyc, bus.out_illegal,
                                  bus.out_taken, bus.out_target, bus.out_result, h.ill, h.tk, h.tgt, h.res);
               end
            end
            total++;
         end
         acc_last = bus.in_valid && bus.in_ready;
         if (acc_last) begin
            t = bus.in_type;
            f = bus.in_func;
            note_accept(t, f);
            if (t == 2'd1) begin
               x_addr  = 32'(longint'({32'h0, bus.in_a}) + longint'({32'h0, bus.in_imm}));
               x_we    = f[0];
               x_wdata = bus.in_b;
            end else begin
               q.push_back(ref_exec(t, f, bus.in_a, bus.in_b, bus.in_imm, bus.in_pc));
            end
         end
         if (ld_wait && bus.mem_rsp_valid) begin
            e = '0;
            e.res = bus.mem_rsp_rdata;
            q.push_back(e);
            ld_wait = 1'b0;
         end
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            if ({bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata[31:0] & {32{x_we}}} !==
                {x_addr, x_we, x_wdata & {32{x_we}}}) begin
               bad++; $display("FAIL rand_mem_req cyc=%0d got=%h/%b/%h want=%h/%b/%h", cyc,
                               bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, x_addr, x_we, x_wdata);
            end
            total++;
            if (x_we) q.push_back('0);
            else ld_wait = 1'b1;
         end
         @(negedge clk);
      end
      if (q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d pending want=0", q.size()); end
      total++;
      if ({bus.cnt_alu, bus.cnt_mem, bus.cnt_branch, bus.cnt_illegal} !==
          {16'(e_alu), 16'(e_mem), 16'(e_br), 16'(e_ill)}) begin
         bad++; $display("FAIL rand_counters got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", bus.cnt_alu, bus.cnt_mem,
                         bus.cnt_branch, bus.cnt_illegal, e_alu, e_mem, e_br, e_ill);
      end
      total++;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.out_ready     = 1'b1;
   endtask

   task automatic test_reset_mid();
      bus.out_ready     = 1'b1;
      bus.mem_req_ready = 1'b0;
      set_op(2'd1, 3'd0, 32'h300, 32'h0, 32'h4, 32'h0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.mem_req_valid !== 1'b1) begin bad++; $display("FAIL rmid_req_up got=%b want=1", bus.mem_req_valid); end
      total++;
      rst_n = 1'b0;
      #1;
      if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b0, 32'h0}) begin
         bad++; $display("FAIL rmid_req_drop got=%b/%h want=0/00000000", bus.mem_req_valid, bus.mem_req_addr);
      end
      total++;
      @(negedge clk);
      rst_n = 1'b1;
      set_op(2'd1, 3'd0, 32'h40, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      bus.in_valid      = 1'b0;
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      e_alu = 0; e_mem = 0; e_br = 0; e_ill = 0;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h5555_AAAA;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if ({bus.out_valid, bus.out_result, bus.mem_req_valid, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
         bad++; $display("FAIL rmid_rsp_ignored got=%b/%h/%b/%b want=0/00000000/0/1",
                         bus.out_valid, bus.out_result, bus.mem_req_valid, bus.in_ready);
      end
      total++;
      if ({bus.cnt_alu, bus.cnt_mem, bus.cnt_branch, bus.cnt_illegal} !== 64'h0) begin
         bad++; $display("FAIL rmid_counters got=%0d/%0d/%0d/%0d want=0", bus.cnt_alu, bus.cnt_mem,
                         bus.cnt_branch, bus.cnt_illegal);
      end
      total++;
   endtask

   task automatic test_sat();
      logic [1:0] want;
      sbus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sbus.in_valid = 1'b1;
         sbus.in_type  = 2'd0;
         sbus.in_func  = 3'd0;
         sbus.in_a     = 32'(i);
         sbus.in_b     = 32'd10;
         @(negedge clk);
         want = (i + 1 > 3) ? 2'd3 : 2'(i + 1);
         if ({sbus.cnt_alu, sbus.out_valid, sbus.out_result} !== {want, 1'b1, 32'(i + 10)}) begin
            bad++; $display("FAIL sat_cnt op=%0d got=%0d/%b/%h want=%0d/1/%h", i, sbus.cnt_alu,
                            sbus.out_valid, sbus.out_result, want, 32'(i + 10));
         end
         total++;
      end
      sbus.in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.in_type = 2'd0; bus.in_func = 3'd0;
      bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0; bus.in_pc = '0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0; bus.out_ready = 1'b1;
      sbus.in_valid = 1'b0; sbus.in_type = 2'd0; sbus.in_func = 3'd0;
      sbus.in_a = '0; sbus.in_b = '0; sbus.in_imm = '0; sbus.in_pc = '0;
      sbus.mem_req_ready = 1'b0; sbus.mem_rsp_valid = 1'b0; sbus.mem_rsp_rdata = '0; sbus.out_ready = 1'b1;
      test_reset();
      test_alu_add();
      test_back_to_back();
      test_branch();
      test_mem();
      test_stall();
      test_random();
      test_reset_mid();
      test_sat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
